// File: rtl/dvi_timing_ctrl.sv
// rtl/dvi_timing_ctrl.sv - DVI timing controller: pixel divider, 800x525 raster scan, TMDS encoder feed; DVI_TEST_PATTERN_EN adds colour-bar test_mode
module dvi_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int BIT_DIV   = 10
) (
  input  logic        clk_fast,
  input  logic        rst,
  input  logic        en,
`ifdef DVI_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        pix_ce,
  output logic        ser_load,
  output logic        pix_req,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  input  logic [23:0] rgb_in,
  output logic [7:0]  vd_r,
  output logic [7:0]  vd_g,
  output logic [7:0]  vd_b,
  output logic        VDE,
  output logic [1:0]  CD,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [1:0]       CD_IDLE  = {~VSYNC_POL, ~HSYNC_POL};

  // Counters are 10 bits wide, so a raster larger than 1024 in either axis cannot be scanned
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("dvi_timing_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
  endgenerate

  logic [DIV_W-1:0] div;
  logic [9:0]       h;
  logic [9:0]       v;
  logic             hsync_act;
  logic             vsync_act;
  logic             hs_lvl;
  logic             vs_lvl;
  logic [23:0]      pix_rgb;

  // Pixel divider and raster counters; en low parks the scan at the frame origin
  always_ff @(posedge clk_fast) begin
    if (rst || !en) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Position-derived strobes; rst masks them so en is ignored while in reset
  assign pix_ce      = !rst && en && (div == DIV_LAST);
  assign ser_load    = !rst && en && (div == '0);
  assign pix_x       = h;
  assign pix_y       = v;
  assign pix_req     = !rst && (h < 10'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
  assign frame_start = !rst && en && (h == 10'd0) && (v == 10'd0);

  // Sync windows compared at 11 bits so a window ending at 1024 does not wrap
  assign hsync_act = ({1'b0, h} >= 11'(H_ACTIVE + H_FP)) &&
                     ({1'b0, h} <  11'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_act = ({1'b0, v} >= 11'(V_ACTIVE + V_FP)) &&
                     ({1'b0, v} <  11'(V_ACTIVE + V_FP + V_SYNC));
  assign hs_lvl    = hsync_act ? HSYNC_POL : ~HSYNC_POL;
  assign vs_lvl    = vsync_act ? VSYNC_POL : ~VSYNC_POL;

`ifdef DVI_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;
  // Bar index bits map directly to colour: R=~bar[1], G=~bar[2], B=~bar[0]
  assign bar     = 3'(h / 10'(BAR_W));
  assign pix_rgb = test_mode ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : rgb_in;
`else
  assign pix_rgb = rgb_in;
`endif

  // Encoder-facing register: captures the pixel that ends on this pix_ce, idles when disabled
  always_ff @(posedge clk_fast) begin
    if (rst || !en) begin
      VDE  <= 1'b0;
      CD   <= CD_IDLE;
      vd_r <= 8'h00;
      vd_g <= 8'h00;
      vd_b <= 8'h00;
    end else if (pix_ce) begin
      VDE  <= pix_req;
      CD   <= {vs_lvl, hs_lvl};
      vd_r <= pix_req ? pix_rgb[23:16] : 8'h00;
      vd_g <= pix_req ? pix_rgb[15:8]  : 8'h00;
      vd_b <= pix_req ? pix_rgb[7:0]   : 8'h00;
    end
  end

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb/tb_dvi_timing_ctrl.sv - scoreboard bench for dvi_timing_ctrl on a reduced raster
module tb_dvi_timing_ctrl;

  // Reduced raster keeps several whole frames within a short run
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int BD = 10;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic        vde;
    logic [1:0]  cd;
    logic [23:0] rgb;
  } exp_t;

  logic        clk_fast = 1'b0;
  logic        rst;
  logic        en;
  logic        test_mode;
  logic        pix_ce, ser_load, pix_req, frame_start;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] rgb_in;
  logic [7:0]  vd_r, vd_g, vd_b;
  logic        VDE;
  logic [1:0]  CD;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mh = 0;
  int   mv = 0;
  bit   tp = 1'b0;
  exp_t sb[$];

  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk_fast = ~clk_fast;

  dvi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .BIT_DIV(BD)
  ) dut (
    .clk_fast(clk_fast),
    .rst(rst),
    .en(en),
`ifdef DVI_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_ce(pix_ce),
    .ser_load(ser_load),
    .pix_req(pix_req),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .rgb_in(rgb_in),
    .vd_r(vd_r),
    .vd_g(vd_g),
    .vd_b(vd_b),
    .VDE(VDE),
    .CD(CD),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_fast);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit in_rst);
    chk({tag, ".pix_ce"}, pix_ce, 0);
    chk({tag, ".ser_load"}, ser_load, 0);
    chk({tag, ".frame_start"}, frame_start, 0);
    chk({tag, ".pix_x"}, pix_x, 0);
    chk({tag, ".pix_y"}, pix_y, 0);
    chk({tag, ".VDE"}, VDE, 0);
    chk({tag, ".CD"}, CD, 2'b11);
    chk({tag, ".vd"}, {vd_r, vd_g, vd_b}, 24'h0);
    if (in_rst) chk({tag, ".pix_req"}, pix_req, 0);
  endtask

  // Entered at a div==0 sample: pops the previous pixel's output, checks position, drives rgb, runs one pixel period
  task automatic pixel_step();
    exp_t        e;
    logic [23:0] rgb;
    logic        req, hs_act, vs_act;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("VDE", VDE, e.vde);
      chk("CD", CD, e.cd);
      chk("vd_rgb", {vd_r, vd_g, vd_b}, e.rgb);
    end
    req = (mh < HA) && (mv < VA);
    chk("pix_x", pix_x, mh);
    chk("pix_y", pix_y, mv);
    chk("pix_req", pix_req, req);
    chk("frame_start", frame_start, (mh == 0) && (mv == 0));
    chk("ser_load_on", ser_load, 1);
    chk("pix_ce_off", pix_ce, 0);
    rgb = 24'($urandom);
    if (mh == 5 && mv == 7) rgb = 24'h123456;
    rgb_in = rgb;
    hs_act = (mh >= HA + HF) && (mh < HA + HF + HS);
    vs_act = (mv >= VA + VF) && (mv < VA + VF + VS);
    e.vde = req;
    e.cd  = {~vs_act, ~hs_act};
    e.rgb = !req ? 24'h0 : (tp ? bar_rgb[mh / (HA / 8)] : rgb);
    sb.push_back(e);
    for (int j = 1; j <= BD - 1; j++) begin
      tick();
      chk("pix_ce", pix_ce, (j == BD - 1));
      chk("ser_load_off", ser_load, 0);
    end
    tick();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    rgb_in    = 24'h0;
    test_mode = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    tick();
    check_idle("reset", 1'b1);

    rst = 1'b0;
    #1;
    for (int p = 0; p < HT * VT + 60; p++) pixel_step();

    repeat (4) tick();
    en = 1'b0;
    tick();
    check_idle("en_drop", 1'b0);
    sb.delete();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_low.pix_ce", pix_ce, 0);
      chk("en_low.ser_load", ser_load, 0);
    end
    en = 1'b1;
    #1;
    mh = 0;
    mv = 0;
    for (int p = 0; p < 80; p++) pixel_step();

`ifdef DVI_TEST_PATTERN_EN
    tp        = 1'b1;
    test_mode = 1'b1;
    for (int p = 0; p < HT; p++) pixel_step();
    tp        = 1'b0;
    test_mode = 1'b0;
    for (int p = 0; p < 2; p++) pixel_step();
`endif

    repeat (BD - 1) tick();
    chk("pre_rst.pix_ce", pix_ce, 1);
    rst = 1'b1;
    tick();
    check_idle("rst_on_ce", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
